// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the three sides of the unified-memory arbiter:
//   - instruction fetch requester : if_req_i, if_addr_i -> if_data_o, if_ack_o
//   - data requester              : d_req_i, d_we_i, d_addr_i, d_wdata_i
//                                    -> d_rdata_o, d_ack_o
//   - backing memory              : mem_req_o, mem_we_o, mem_addr_o,
//                                    mem_wdata_o <- mem_rdata_i, mem_ack_i
//   - status                      : stall_o, err_o
// Signal suffixes are written from the arbiter's point of view.
// Modports:
//   slave  - the arbiter itself
//   master - the environment (pipeline stages plus backing memory)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_data_o;
  logic              if_ack_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_ack_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  logic              stall_o;
  logic              err_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
    input  mem_rdata_i, mem_ack_i,
    output if_data_o, if_ack_o, d_rdata_o, d_ack_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output stall_o, err_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i,
    output mem_rdata_i, mem_ack_i,
    input  if_data_o, if_ack_o, d_rdata_o, d_ack_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  stall_o, err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between instruction fetch and data access.
// Each granted access is presented to the memory with a req/ack handshake,
// completed with a one-cycle ack pulse back to the requester, and the pipeline
// is stalled while any request is outstanding. A memory that never answers is
// cut off after MAX_WAIT cycles: the requester still gets its ack (data left
// unchanged) and the sticky err_o flag is raised.
//
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous, active-high reset
//   bus    - mem_port_arbiter_if.slave (requesters, memory, stall/err)
//
// Parameters: ADDR_W, DATA_W, MAX_WAIT (>= 1, timeout in SERV cycles)
//
// Build option: define ARB_RR_EN to alternate grants between the two
// requesters on collisions; otherwise data always wins over fetch.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_port_arbiter_if.slave bus
);

  localparam int                CNT_W     = $clog2(MAX_WAIT + 1);
  // Counter value at the end of the last permitted SERV cycle.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, SERV_I, SERV_D, RESP} state_e;

  // Every piece of registered state, so reset and update are one assignment.
  typedef struct packed {
    state_e            state;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] if_data;
    logic [DATA_W-1:0] d_rdata;
    logic              if_ack;
    logic              d_ack;
    logic              err;
    logic [CNT_W-1:0]  wait_cnt;
`ifdef ARB_RR_EN
    logic              last_d;   // 1 = data was granted last, 0 = fetch
`endif
  } regs_t;

  regs_t q, d;
  logic  grant_d;
  logic  in_serv;
  logic  timeout;

`ifdef ARB_RR_EN
  // On a collision the requester not served last wins.
  assign grant_d = bus.d_req_i & (~bus.if_req_i | ~q.last_d);
`else
  assign grant_d = bus.d_req_i;
`endif

  assign in_serv = (q.state == SERV_I) || (q.state == SERV_D);
  // An ack arriving in the final permitted cycle wins over the timeout.
  assign timeout = in_serv && !bus.mem_ack_i && (q.wait_cnt == LAST_WAIT);

  // NOTE: every field of d starts from its held value before the case, so no
  // path through this block can leave a signal unassigned and infer a latch.
  always_comb begin
    d        = q;
    d.if_ack = 1'b0;
    d.d_ack  = 1'b0;
    case (q.state)
      IDLE: begin
        if (grant_d) begin
          d.state     = SERV_D;
          d.mem_req   = 1'b1;
          d.mem_we    = bus.d_we_i;
          d.mem_addr  = bus.d_addr_i;
          d.mem_wdata = bus.d_wdata_i;
          d.wait_cnt  = '0;
`ifdef ARB_RR_EN
          d.last_d    = 1'b1;
`endif
        end else if (bus.if_req_i) begin
          d.state     = SERV_I;
          d.mem_req   = 1'b1;
          d.mem_we    = 1'b0;
          d.mem_addr  = bus.if_addr_i;
          d.mem_wdata = '0;
          d.wait_cnt  = '0;
`ifdef ARB_RR_EN
          d.last_d    = 1'b0;
`endif
        end
      end
      SERV_I, SERV_D: begin
        if (bus.mem_ack_i) begin
          if (q.state == SERV_I) begin
            d.if_data = bus.mem_rdata_i;
          end else if (!q.mem_we) begin
            d.d_rdata = bus.mem_rdata_i;
          end
        end else begin
          d.wait_cnt = q.wait_cnt + CNT_W'(1);
        end
        if (timeout) begin
          d.err = 1'b1;
        end
        if (bus.mem_ack_i || timeout) begin
          d.state   = RESP;
          d.mem_req = 1'b0;
          d.if_ack  = (q.state == SERV_I);
          d.d_ack   = (q.state == SERV_D);
        end
      end
      RESP:    d.state = IDLE;
      default: d.state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge value of everything else.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

  assign bus.mem_req_o   = q.mem_req;
  assign bus.mem_we_o    = q.mem_we;
  assign bus.mem_addr_o  = q.mem_addr;
  assign bus.mem_wdata_o = q.mem_wdata;
  assign bus.if_data_o   = q.if_data;
  assign bus.if_ack_o    = q.if_ack;
  assign bus.d_rdata_o   = q.d_rdata;
  assign bus.d_ack_o     = q.d_ack;
  assign bus.err_o       = q.err;

  // A requester stalls the pipeline until its own ack cycle; held low in reset.
  assign bus.stall_o = ~rst_i & ((bus.if_req_i & ~q.if_ack) |
                                 (bus.d_req_i  & ~q.d_ack));

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates one shared single-port memory between the pipeline's instruction fetch (IF) and data access (MEM) requesters. Sequences each access with a req/ack handshake towards a variable-latency backing memory. Drives a pipeline stall while any request is outstanding. Sits between the IF/MEM stages and the unified memory, in place of the separate instruction and data memories.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width of all data ports
MAX_WAIT, 255, memory-ack timeout in cycles; must be at least 1; counter width is clog2(MAX_WAIT+1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
if_req_i  in  1  instruction fetch request; held until if_ack_o
if_addr_i  in  ADDR_W  fetch address; stable while if_req_i is high
if_data_o  out  DATA_W  fetched instruction; valid when if_ack_o is high, held after
if_ack_o  out  1  one-cycle completion pulse for a fetch
d_req_i  in  1  data request; held until d_ack_o
d_we_i  in  1  1 = write, 0 = read; stable while d_req_i is high
d_addr_i  in  ADDR_W  data address
d_wdata_i  in  DATA_W  write data
d_rdata_o  out  DATA_W  read data; valid when d_ack_o is high, held after
d_ack_o  out  1  one-cycle completion pulse for a data access
mem_req_o  out  1  request to backing memory
mem_we_o  out  1  write enable to memory
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data; valid with mem_ack_i
mem_ack_i  in  1  memory completion, one cycle
stall_o  out  1  pipeline stall
err_o  out  1  sticky timeout flag

Behaviour:
- Reset (synchronous, rst_i high at an edge) clears all registered outputs and internal state to 0 and puts the FSM in IDLE. This includes if_data_o, d_rdata_o, both acks, all mem_* outputs, err_o and the wait counter.
- FSM states: IDLE, SERV_I, SERV_D, RESP.
- IDLE, choosing the next grant:
  - d_req_i=1 -> SERV_D.
  - else if_req_i=1 -> SERV_I.
  - Both high: SERV_D (data has fixed priority).
- On entry to SERV_x, register mem_req_o=1 with mem_addr_o/mem_we_o/mem_wdata_o from requester x. For IF: mem_we_o=0 and mem_wdata_o=0.
- SERV_x holds all mem_* outputs stable until mem_ack_i is sampled high.
- On that edge: capture mem_rdata_i into if_data_o (IF) or d_rdata_o (data read only; writes leave d_rdata_o unchanged). Then go to RESP with mem_req_o=0.
- RESP lasts exactly one cycle: x_ack_o=1, then back to IDLE.
- Latency: a request sampled at edge k with a zero-wait memory (ack in the first SERV cycle) gives mem_req_o high in cycle k+1 and x_ack_o high in cycle k+2. Each memory wait cycle adds 1.
- Requester handshake: the requester drops or changes x_req_i at the edge after seeing x_ack_o. A request still high in IDLE after RESP counts as a new request.
- mem_ack_i is ignored in IDLE and RESP.
- stall_o = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o). This is combinational and is 0 during reset.
- Wait counter: cleared on SERV entry and incremented each SERV cycle without mem_ack_i.
- Timeout: when the counter reaches MAX_WAIT, err_o is set (sticky until reset) and the FSM goes to RESP. The ack is pulsed with data unchanged, so the pipeline never deadlocks.
- Reset mid-access: the access is abandoned and mem_req_o is 0 in the cycle after reset. A late mem_ack_i is ignored.
- mem_ack_i coinciding with the MAX_WAIT cycle: treated as a normal completion; err_o is not set.

Optional Feature:
ARB_RR_EN: enables round-robin priority.
- Defined: a 1-bit last-grant register (reset = IF). When both requests are pending in IDLE, grant goes to the requester not served last.
- Undefined: fixed data-over-instruction priority; no last-grant register.

Test Plan:
- Fetch only, zero-wait memory:
  - Stimulus: if_req_i=1, if_addr_i=0x10; memory acks in the first cycle with 0x8C220004.
  - Required: mem_req_o high 1 cycle with mem_addr_o=0x10; if_ack_o pulses at k+2 with if_data_o=0x8C220004; stall_o high k..k+1.
- Data write, 3 wait cycles:
  - Stimulus: d_we_i=1, d_addr_i=0x40, d_wdata_i=0x5; memory acks on the 4th SERV cycle.
  - Required: mem_we_o=1 held 4 cycles; d_ack_o at k+5; d_rdata_o unchanged.
- Simultaneous if_req_i and d_req_i:
  - Without ARB_RR_EN: data served first, fetch next.
  - With ARB_RR_EN over back-to-back collisions: grants alternate D, I, D, I.
- Timeout with MAX_WAIT=4:
  - Stimulus: memory never acks.
  - Required: ack pulses after 4 SERV cycles; err_o=1 and remains 1 over subsequent accesses until rst_i.
- Reset mid-access:
  - Stimulus: rst_i high during SERV_D; memory acks 2 cycles later.
  - Required: mem_req_o=0 in the cycle after reset, d_ack_o never pulses, state is IDLE, outputs are 0.
- Ack-edge collision:
  - Stimulus: mem_ack_i asserted in the MAX_WAIT cycle.
  - Required: normal completion with the captured data; err_o stays 0.
